// File: rtl/mem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_pkg
// Shared definitions for the memory-stage access controller:
//   - state_t        : FSM state encoding (ST_IDLE .. ST_DONE)
//   - BE_*           : byte-enable patterns for the four lanes and full word
//   - timeout_width  : bit width needed to count up to a given TIMEOUT value
// -----------------------------------------------------------------------------
package mem_access_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam logic [3:0] BE_BYTE1 = 4'b0010;
  localparam logic [3:0] BE_BYTE2 = 4'b0100;
  localparam logic [3:0] BE_BYTE3 = 4'b1000;
  localparam logic [3:0] BE_WORD  = 4'b1111;

  // Width of a counter that can hold 0..timeout, i.e. clog2(timeout+1).
  function automatic int timeout_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// -----------------------------------------------------------------------------
// mem_lane_steer
// Combinational byte-lane steering between the pipeline and a 4-lane,
// little-endian data memory.
//   byteword   in   0 = byte access, 1 = word access
//   lane       in   byte offset within the word (addr[1:0])
//   wdata      in   store data from the pipeline
//   mem_rdata  in   raw word read from memory
//   be         out  byte enables for the request
//   lane_wdata out  store data placed on the memory lanes
//   load_data  out  load result (zero-extended byte or full word)
// -----------------------------------------------------------------------------
module mem_lane_steer
  import mem_access_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              byteword,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] lane_wdata,
  output logic [DATA_W-1:0] load_data
);

  logic [7:0] rd_byte;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    be         = BE_WORD;
    lane_wdata = wdata;
    load_data  = mem_rdata;
    rd_byte    = mem_rdata[{lane, 3'b000} +: 8];

    if (!byteword) begin
      unique case (lane)
        2'd0: be = BE_BYTE0;
        2'd1: be = BE_BYTE1;
        2'd2: be = BE_BYTE2;
        2'd3: be = BE_BYTE3;
      endcase
      // Replicating the byte on every lane lets memory pick it up with be alone.
      lane_wdata = {4{wdata[7:0]}};
      load_data  = DATA_W'(rd_byte);
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
// Memory-stage responder: turns memread/memwrite/byteword + address/store data
// into a req/ack transaction on the data-memory bus, stalls the pipeline until
// the access completes and returns load data to the WB-stage mux.
//   clk, rst_n            clock, asynchronous active-low reset
//   memread, memwrite     M-stage access controls (both high = illegal op)
//   byteword              0 = byte, 1 = word
//   addr, wdata           effective address, store data
//   stall_o               freezes upstream pipeline registers
//   rdata_o, rdata_vld_o  load result and its 1-cycle valid pulse
//   align_err_o           misaligned word access, 1-cycle pulse
//   bus_err_o             illegal op or ack timeout, 1-cycle pulse
//   mem_req/we/addr/be/wdata  request to memory, held until mem_ack
//   mem_ack, mem_rdata        completion and read data from memory
// -----------------------------------------------------------------------------
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memread,
  input  logic              memwrite,
  input  logic              byteword,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rdata_vld_o,
  output logic              align_err_o,
  output logic              bus_err_o,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int             TO_W    = timeout_width(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                we_q, bw_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [TO_W-1:0]     cnt_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                bus_err_q, align_err_q;
  logic                block_q;

  logic                acc, illegal, misaligned, valid, in_idle, busy, timeout;
  logic [3:0]          be;
  logic [DATA_W-1:0]   lane_wdata, load_data;

  // ---------------------------------------------------------------- decode
  assign acc        = memread ^ memwrite;
  assign illegal    = memread & memwrite;
  assign misaligned = acc & byteword & (addr[1:0] != 2'b00);
  assign in_idle    = (state_q == ST_IDLE) && !block_q;
  assign valid      = in_idle & acc & ~misaligned;
  assign busy       = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign timeout    = (state_q == ST_WAIT) && !mem_ack && (cnt_q == TO_LAST);

  // Steering works from the latched request so fields stay stable in REQ/WAIT
  // and the load lane matches the address the request was issued with.
  mem_lane_steer #(.DATA_W(DATA_W)) u_steer (
    .byteword   (bw_q),
    .lane       (addr_q[1:0]),
    .wdata      (wdata_q),
    .mem_rdata  (mem_rdata),
    .be         (be),
    .lane_wdata (lane_wdata),
    .load_data  (load_data)
  );

  // ------------------------------------------------------------ next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (valid) state_d = ST_REQ;
      ST_REQ:  state_d = mem_ack ? ST_DONE : ST_WAIT;
      ST_WAIT: begin
        if (mem_ack)      state_d = ST_DONE;
        else if (timeout) state_d = ST_IDLE;
      end
      ST_DONE: state_d = ST_IDLE;
    endcase
  end

  // ------------------------------------------------------------- registers
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      bw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      bus_err_q   <= 1'b0;
      align_err_q <= 1'b0;
      block_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      bus_err_q   <= (in_idle & illegal) | timeout;
      align_err_q <= in_idle & misaligned;
      // After a timeout the faulting instruction is still on the inputs for
      // one cycle while the pipeline advances; it must not be re-issued.
      block_q     <= timeout;

      if (valid) begin
        we_q    <= memwrite;
        bw_q    <= byteword;
        addr_q  <= addr;
        wdata_q <= wdata;
      end

      if (state_q == ST_REQ)                   cnt_q <= '0;
      else if (state_q == ST_WAIT && !mem_ack) cnt_q <= cnt_q + 1'b1;

      if (busy && mem_ack && !we_q) rdata_q <= load_data;
    end
  end

  // --------------------------------------------------------------- outputs
  // rst_n gates the combinational stall so it reads 0 during reset even if the
  // pipeline still presents an access.
  assign stall_o     = rst_n & (valid | busy);
  assign rdata_o     = rdata_q;
  assign rdata_vld_o = (state_q == ST_DONE) && !we_q;
  assign align_err_o = align_err_q;
  assign bus_err_o   = bus_err_q;

  // Request fields read as zero whenever no request is outstanding.
  assign mem_req   = busy;
  assign mem_we    = busy & we_q;
  assign mem_addr  = busy ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
  assign mem_be    = busy ? be : 4'b0000;
  assign mem_wdata = busy ? lane_wdata : '0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
// Self-checking bench: directed accesses plus randomized traffic, every cycle
// compared against expectations computed from the access rules (lane math,
// cycle counts) rather than from the controller's internals.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 255;

  logic              clk;
  logic              rst_n;
  logic              memread, memwrite, byteword;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              stall_o;
  logic [DATA_W-1:0] rdata_o;
  logic              rdata_vld_o, align_err_o, bus_err_o;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_rd = '0;   // model: last completed load result

  mem_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .memread     (memread),
    .memwrite    (memwrite),
    .byteword    (byteword),
    .addr        (addr),
    .wdata       (wdata),
    .stall_o     (stall_o),
    .rdata_o     (rdata_o),
    .rdata_vld_o (rdata_vld_o),
    .align_err_o (align_err_o),
    .bus_err_o   (bus_err_o),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    memread  = 1'b0;
    memwrite = 1'b0;
    byteword = 1'b0;
    addr     = '0;
    wdata    = '0;
    mem_ack  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, 32'(stall_o), 32'd0);
    check({tag, "_req"},   32'(mem_req), 32'd0);
    check({tag, "_we"},    32'(mem_we), 32'd0);
    check({tag, "_addr"},  mem_addr, 32'd0);
    check({tag, "_be"},    32'(mem_be), 32'd0);
    check({tag, "_wdat"},  mem_wdata, 32'd0);
    check({tag, "_rdat"},  rdata_o, 32'd0);
    check({tag, "_vld"},   32'(rdata_vld_o), 32'd0);
    check({tag, "_aerr"},  32'(align_err_o), 32'd0);
    check({tag, "_berr"},  32'(bus_err_o), 32'd0);
  endtask

  // One pipeline access. delay = number of WAIT cycles before ack (0 = ack in
  // REQ); delay < 0 means memory never acks. mrd is the word memory returns.
  task automatic run_access(input bit rd, input bit wr, input bit bw,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int delay, input logic [31:0] mrd);
    bit          acc, mis, illegal, ack;
    int          req_cycles, sh;
    logic [31:0] exp_addr, exp_wdata, exp_rd;
    logic [3:0]  exp_be;

    acc     = rd ^ wr;
    illegal = rd & wr;
    mis     = acc && bw && (a[1:0] != 2'b00);
    sh      = 8 * int'(a[1:0]);
    exp_addr  = {a[31:2], 2'b00};
    exp_be    = bw ? 4'hF : 4'(1 << a[1:0]);
    exp_wdata = bw ? wd : {4{wd[7:0]}};
    exp_rd    = bw ? mrd : ((mrd >> sh) & 32'h0000_00FF);

    @(posedge clk); #1;
    memread = rd; memwrite = wr; byteword = bw; addr = a; wdata = wd;
    mem_ack = 1'b0; mem_rdata = $urandom;
    @(negedge clk);

    if (!acc || mis) begin
      check("rej_stall", 32'(stall_o), 32'd0);
      check("rej_req",   32'(mem_req), 32'd0);
      @(posedge clk); #1; clear_inputs();
      @(negedge clk);
      check("rej_berr", 32'(bus_err_o), 32'(illegal));
      check("rej_aerr", 32'(align_err_o), 32'(mis));
      check("rej_req2", 32'(mem_req), 32'd0);
      check("rej_vld",  32'(rdata_vld_o), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("rej_pulse_end", 32'({bus_err_o, align_err_o}), 32'd0);
      return;
    end

    check("acc_stall0", 32'(stall_o), 32'd1);
    check("acc_req0",   32'(mem_req), 32'd0);

    req_cycles = (delay < 0) ? TIMEOUT + 1 : delay + 1;
    for (int c = 0; c < req_cycles; c++) begin
      @(posedge clk); #1;
      ack       = (delay >= 0) && (c == delay);
      mem_ack   = ack;
      mem_rdata = ack ? mrd : $urandom;
      @(negedge clk);
      check("req_stall", 32'(stall_o), 32'd1);
      check("req_req",   32'(mem_req), 32'd1);
      check("req_we",    32'(mem_we), 32'(wr));
      check("req_addr",  mem_addr, exp_addr);
      if (wr || bw) check("req_be", 32'(mem_be), 32'(exp_be));
      if (wr)       check("req_wdata", mem_wdata, exp_wdata);
      check("req_berr",  32'(bus_err_o), 32'd0);
      check("req_vld",   32'(rdata_vld_o), 32'd0);
    end

    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = $urandom;
    @(negedge clk);
    if (delay < 0) begin
      // Instruction still presented, yet it must not be re-issued.
      check("to_berr",  32'(bus_err_o), 32'd1);
      check("to_req",   32'(mem_req), 32'd0);
      check("to_stall", 32'(stall_o), 32'd0);
      check("to_vld",   32'(rdata_vld_o), 32'd0);
      check("to_rdata", rdata_o, last_rd);
    end else begin
      if (rd) last_rd = exp_rd;
      check("done_stall", 32'(stall_o), 32'd0);
      check("done_req",   32'(mem_req), 32'd0);
      check("done_vld",   32'(rdata_vld_o), 32'(rd));
      check("done_rdata", rdata_o, last_rd);
    end

    @(posedge clk); #1; clear_inputs();
    @(negedge clk);
    check("post_vld",   32'(rdata_vld_o), 32'd0);
    check("post_req",   32'(mem_req), 32'd0);
    check("post_stall", 32'(stall_o), 32'd0);
    check("post_berr",  32'(bus_err_o), 32'd0);
    check("post_rdata", rdata_o, last_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          rd, wr, bw;
    int          op;
    logic [31:0] a;

    clear_inputs();
    mem_rdata = '0;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1; rst_n = 1'b1;

    // Directed cases
    run_access(1, 0, 1, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF);
    run_access(0, 1, 0, 32'h0000_0203, 32'h0000_00A5, 3, 32'h0);
    run_access(1, 0, 0, 32'h0000_0301, 32'h0, 1, 32'h1122_3344);
    run_access(1, 0, 1, 32'h0000_0102, 32'h0, 0, 32'h0);
    run_access(0, 1, 1, 32'h0000_0400, 32'h1234_5678, -1, 32'h0);
    run_access(1, 0, 1, 32'h0000_0404, 32'h0, TIMEOUT, 32'hCAFE_F00D);
    run_access(0, 1, 1, 32'h0000_0408, 32'h0BAD_C0DE, 2, 32'h0);

    // Reset in the middle of WAIT, then a stray ack after reset
    @(posedge clk); #1;
    memread = 1'b1; memwrite = 1'b0; byteword = 1'b1; addr = 32'h0000_0500;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre_rst_req", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(posedge clk); #1;
    rst_n = 1'b1; clear_inputs();
    mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
    last_rd = '0;
    @(negedge clk);
    check("late_ack_vld", 32'(rdata_vld_o), 32'd0);
    check("late_ack_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1; mem_ack = 1'b0;
    @(negedge clk);
    check_all_zero("after_late_ack");
    run_access(1, 1, 1, 32'h0000_0600, 32'h0, 0, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 9);
      rd = (op <= 4) || (op == 9);
      wr = (op >= 5);
      if (op == 8) rd = 1'b0;
      if (op == 0) wr = 1'b1;        // occasional illegal op
      bw = $urandom_range(0, 1) == 1;
      a  = $urandom;
      if (bw && $urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      run_access(rd, wr, bw, a, $urandom, $urandom_range(0, 5), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
